mips_divider: RTL and testbench



---
 rtl/mips_divider_pkg.sv | 23 ++
 rtl/mips_divider_div_step.sv | 25 ++
 rtl/mips_divider.sv | 123 ++++++++++++
 tb/tb_mips_divider.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_divider_pkg.sv
// mips_divider shared types and constants.
// State encoding, widths and a sign-magnitude helper.
package mips_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  // Two's-complement negate when s is set.
  function automatic logic [DIV_WIDTH-1:0] mag(
    input logic [DIV_WIDTH-1:0] v,
    input logic                 s
  );
    return s ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mips_divider_div_step.sv
// One restoring-division iteration.
// Shifts in a dividend bit and trial-subtracts the divisor.
module div_step
  import mips_divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic                 din,
  input  logic [DIV_WIDTH-1:0] dvs,
  output logic [DIV_WIDTH-1:0] rem_nxt,
  output logic                 qbit
);

  logic [DIV_WIDTH:0]   sh;
  logic [DIV_WIDTH-1:0] diff;

  // The shifted remainder is < 2*dvs, so when it is not
  // below dvs the low-word difference is exact.
  always_comb begin
    sh      = {rem, din};
    diff    = sh[DIV_WIDTH-1:0] - dvs;
    qbit    = (sh >= {1'b0, dvs});
    rem_nxt = qbit ? diff : sh[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle 32-bit DIV/DIVU unit: quotient on lo, remainder on hi.
// Optional divide-by-zero flag output dz with MIPS_DIVIDER_DZ_EN.
module mips_divider
  import mips_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             instr,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done
`ifdef MIPS_DIVIDER_DZ_EN
  ,
  output logic             dz
`endif
);

  localparam logic [DIV_CNT_W-1:0] LAST =
    DIV_CNT_W'(DIV_ITERS - 1);

  state_t state, nstate;

  logic [DIV_WIDTH-1:0] rem, quo, dvs, aorig;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 qneg, rneg, bz;
  logic                 sgn_a, sgn_b;
  logic [DIV_WIDTH-1:0] rem_nxt;
  logic                 qbit;

  assign sgn_a = instr & a[DIV_WIDTH-1];
  assign sgn_b = instr & b[DIV_WIDTH-1];
  assign busy  = (state != IDLE);

  div_step u_step (
    .rem     (rem),
    .din     (quo[DIV_WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic; start is ignored outside IDLE.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (cnt == LAST) nstate = FIX;
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      aorig <= '0;
      cnt   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      bz    <= 1'b0;
      lo    <= '0;
      hi    <= '0;
      done  <= 1'b0;
`ifdef MIPS_DIVIDER_DZ_EN
      dz    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MIPS_DIVIDER_DZ_EN
      dz   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            quo   <= mag(a, sgn_a);
            dvs   <= mag(b, sgn_b);
            aorig <= a;
            cnt   <= '0;
            qneg  <= sgn_a ^ sgn_b;
            rneg  <= sgn_a;
            bz    <= (b == '0);
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= {quo[DIV_WIDTH-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
`ifdef MIPS_DIVIDER_DZ_EN
          dz   <= bz;
`endif
          if (bz) begin
            lo <= '1;
            hi <= aorig;
          end else begin
            lo <= mag(quo, qneg);
            hi <= mag(rem, rneg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
// Self-checking bench for mips_divider.
// Vector table plus scoreboard; handshake and reset sequences.
module tb_mips_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        instr;
  logic [31:0] lo, hi;
  logic        busy, done;
`ifdef MIPS_DIVIDER_DZ_EN
  logic        dz;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        instr;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];

  always #5 clk = ~clk;

  mips_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .instr (instr),
    .lo    (lo),
    .hi    (hi),
    .busy  (busy),
    .done  (done)
`ifdef MIPS_DIVIDER_DZ_EN
    ,
    .dz    (dz)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %08h expected %08h",
               nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [31:0] x, y,
    input  logic        s,
    output logic [31:0] q, r,
    output logic        d
  );
    int sx, sy;
    d = 1'b0;
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
      d = 1'b1;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = x;
        r = 0;
      end else begin
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  task automatic push(input logic [31:0] l, h,
                      input logic d);
    exp_t e;
    e.lo = l;
    e.hi = h;
    e.dz = d;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ia, ib,
                       input logic ii);
    a     = ia;
    b     = ib;
    instr = ii;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string nm,
                           input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no done within 40 cycles", nm);
      sb.delete();
    end else begin
      chk(nm, lat, exp_lat);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(posedge clk) begin
    #1;
    if (busy && done) begin
      compared++;
      mismatched++;
      $display("FAIL busy_done_overlap: both high");
    end
    if (done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: lo=%08h hi=%08h",
                 lo, hi);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("lo", lo, e.lo);
        chk("hi", hi, e.hi);
`ifdef MIPS_DIVIDER_DZ_EN
        chk("dz", 32'(dz), 32'(e.dz));
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rl, rh, ra, rb;
    logic        rd, ri;

    vt[0]  = '{32'hFFFF_FFFE, 32'd2, 1'b1,
               32'hFFFF_FFFF, 32'd0, 1'b0};
    vt[1]  = '{32'hFFFF_FFFE, 32'd2, 1'b0,
               32'h7FFF_FFFF, 32'd0, 1'b0};
    vt[2]  = '{32'hFFFF_FFF9, 32'd2, 1'b1,
               32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vt[3]  = '{32'd7, 32'hFFFF_FFFE, 1'b1,
               32'hFFFF_FFFD, 32'd1, 1'b0};
    vt[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
               32'h8000_0000, 32'd0, 1'b0};
    vt[5]  = '{32'd5, 32'd0, 1'b0,
               32'hFFFF_FFFF, 32'd5, 1'b1};
    vt[6]  = '{32'd5, 32'd0, 1'b1,
               32'hFFFF_FFFF, 32'd5, 1'b1};
    vt[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               32'd0, 32'h8000_0000, 1'b0};
    vt[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'd1, 32'd0, 1'b0};
    vt[9]  = '{32'd100, 32'd7, 1'b0,
               32'd14, 32'd2, 1'b0};
    vt[10] = '{32'hFFFF_FFF9, 32'd0, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
    vt[11] = '{32'd0, 32'd5, 1'b1,
               32'd0, 32'd0, 1'b0};
    vt[12] = '{32'hDEAD_BEEF, 32'h10, 1'b0,
               32'h0DEA_DBEE, 32'hF, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    instr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, each issued on the previous done cycle.
    for (int i = 0; i < 13; i++) begin
      push(vt[i].lo, vt[i].hi, vt[i].dz);
      issue(vt[i].a, vt[i].b, vt[i].instr);
      wait_done("latency", 33);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> (i % 24));
      ri = 1'(i % 2);
      model(ra, rb, ri, rl, rh, rd);
      push(rl, rh, rd);
      issue(ra, rb, ri);
      wait_done("rand_latency", 33);
    end

    // Results hold after done.
    repeat (5) @(posedge clk);
    #1;
    chk("hold_lo", lo, rl);
    chk("hold_hi", hi, rh);

    // start while busy is ignored.
    push(32'd14, 32'd2, 1'b0);
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    a     = 32'd9;
    b     = 32'd3;
    instr = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignored_start_lat", 28);
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_hold_lo", lo, 32'd14);

    // Back-to-back start on the done cycle.
    push(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("b2b_first_lat", 33);
    push(32'd33, 32'd1, 1'b0);
    issue(32'd100, 32'd3, 1'b0);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done("b2b_second_lat", 33);

    // Reset during iteration 10 aborts without a result.
    issue(32'd1000, 32'd10, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_hi", hi, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_lo_kept", lo, 32'd0);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL leftover: %0d results never seen",
               sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
